vs_result_buffer: RTL and testbench
===================================

VS_RESULT_BUFFER -- requirements
Module: vs_result_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: result word width.
REQ-002 SHALL have parameter DEPTH, default 8: entry count, power of two, at least 2; IDX_W = $clog2(DEPTH).
REQ-003 SHALL have parameter NUM_RD, default 2: independent read ports.
REQ-004 SHALL use one clock; reset is asynchronous and active-high.
REQ-005 ports: clk  in  1  clock, rising edge.
REQ-006 ports: rst  in  1  async active-high reset.
REQ-007 ports: alloc_req  in  1  request one entry.
REQ-008 ports: alloc_gnt  out  1  grant, same cycle.
REQ-009 ports: alloc_idx  out  IDX_W  granted index.
REQ-010 ports: wr_en  in  1 / wr_idx  in  IDX_W / wr_data  in  DATA_WIDTH  result write.
REQ-011 ports: rd_idx  in  NUM_RD*IDX_W  read indices.
REQ-012 ports: rd_data  out  NUM_RD*DATA_WIDTH / rd_valid  out  NUM_RD  read results.
REQ-013 ports: rel_en  in  1 / rel_idx  in  IDX_W  pickup/release.
REQ-014 ports: flush  in  1  free all entries.
REQ-015 ports: full  out  1 / empty  out  1 / count  out  IDX_W+1  occupancy.
REQ-016 ports: err_wr  out  1  illegal write.

Function
REQ-017 Each entry SHALL hold a state FREE, ALLOC or VALID plus a DATA_WIDTH word.
REQ-018 alloc_gnt SHALL equal alloc_req & !full & !flush, combinationally.
REQ-019 alloc_idx SHALL be the lowest-index FREE entry; when no entry is FREE it SHALL be 0.
REQ-020 On a grant, the entry SHALL move FREE->ALLOC at the next edge.
REQ-021 wr_en to an ALLOC entry SHALL store wr_data and move the entry to VALID at the next edge.
REQ-022 wr_en to a FREE or VALID entry SHALL be ignored and SHALL pulse err_wr high for exactly the following cycle.
REQ-023 For port p, rd_valid[p] SHALL be 1 iff entry rd_idx[p] is VALID; rd_data[p] SHALL be that entry's data, otherwise 0 (combinational).
REQ-024 rel_en SHALL move ALLOC or VALID ->FREE at the next edge; release of a FREE entry SHALL be a no-op.
REQ-025 Write and release to the same index in the same cycle: release SHALL win, and err_wr SHALL stay 0.
REQ-026 Alloc and release in the same cycle: the allocator SHALL not see the released entry until the next cycle.
REQ-027 count SHALL update at the next edge by +grant -effective_release; full = (count==DEPTH); empty = (count==0).
REQ-028 flush SHALL free all entries at the next edge, overriding alloc, write and release; count SHALL become 0.

Reset
REQ-029 rst SHALL immediately set all entries FREE, all data 0, count 0, empty 1, full 0, err_wr 0, alloc_gnt 0, and all rd_valid 0.
REQ-030 Reset asserted mid-operation SHALL discard pending writes; the first grant after deassertion SHALL be index 0.

Configuration
REQ-031 Macro VS_RB_BYPASS_EN defined: a read of an ALLOC entry being written this cycle SHALL return wr_data with rd_valid=1 in the same cycle, unless that entry is released or flushed this cycle.
REQ-032 VS_RB_BYPASS_EN undefined: no forwarding; rd_valid becomes 1 one cycle after the write.

Structure
REQ-033 The RBEntryStateType enum (RB_FREE, RB_ALLOC, RB_VALID) SHALL live in package VSTypes.
REQ-034 DATA_WIDTH, DEPTH and NUM_RD defaults SHALL derive from RESULT_BUFFER_SIZE and existing package parameters.
REQ-035 Lowest-free selection SHALL be in sub-module vs_rb_alloc_picker, a parametrised priority encoder over DEPTH free bits.

Verification
REQ-036 Reset, then alloc_req for 8 consecutive cycles -> alloc_idx 0..7; full=1, count=8 after the 8th edge; 9th request gives alloc_gnt=0.
REQ-037 Alloc idx 3, then write 0xDEADBEEF to idx 3 -> next cycle rd_idx[0]=3 gives rd_valid[0]=1, rd_data[0]=0xDEADBEEF.
REQ-038 Write to FREE idx 5 -> err_wr=1 for one cycle, state and count unchanged.
REQ-039 Full buffer; release idx 2 and alloc_req in the same cycle -> alloc_gnt=0; next cycle alloc_idx=2, alloc_gnt=1.
REQ-040 With 4 entries valid, flush+alloc_req+wr_en asserted together -> count=0, empty=1, all rd_valid=0, no grant.
REQ-041 VS_RB_BYPASS_EN defined, same-cycle write 0x12 and read of idx 1 -> rd_valid=1, rd_data=0x12; macro undefined -> rd_valid=0 that cycle, 1 the next.

Source files
------------

// File: rtl/vs_result_buffer_pkg.sv
// Shared result-buffer types and the sizing parameters that set vs_result_buffer defaults.
package VSTypes;
    localparam int XLEN                  = 32;
    localparam int RESULT_BUFFER_SIZE    = 8;
    localparam int NUM_RESULT_READ_PORTS = 2;

    typedef enum logic [1:0] {
        RB_FREE  = 2'd0,
        RB_ALLOC = 2'd1,
        RB_VALID = 2'd2
    } RBEntryStateType;
endpackage

// File: rtl/vs_result_buffer_alloc_picker.sv
// Priority encoder returning the lowest set bit of the free vector (0 when none is set).
module vs_rb_alloc_picker #(
    parameter  int DEPTH = 8,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0] free,
    output logic [IDX_W-1:0] idx
);
    always_comb begin
        idx = '0;
        // Scan downwards so the lowest free index is the last one to assign.
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (free[i]) idx = IDX_W'(i);
        end
    end
endmodule

// File: rtl/vs_result_buffer.sv
// Result buffer: entries are allocated, written once, read by NUM_RD ports, then released.
// Optional macro VS_RB_BYPASS_EN forwards a same-cycle write to matching read ports.
module vs_result_buffer
    import VSTypes::*;
#(
    parameter  int DATA_WIDTH = XLEN,
    parameter  int DEPTH      = RESULT_BUFFER_SIZE,
    parameter  int NUM_RD     = NUM_RESULT_READ_PORTS,
    localparam int IDX_W      = $clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         alloc_req,
    output logic                         alloc_gnt,
    output logic [IDX_W-1:0]             alloc_idx,
    input  logic                         wr_en,
    input  logic [IDX_W-1:0]             wr_idx,
    input  logic [DATA_WIDTH-1:0]        wr_data,
    input  logic [NUM_RD*IDX_W-1:0]      rd_idx,
    output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
    output logic [NUM_RD-1:0]            rd_valid,
    input  logic                         rel_en,
    input  logic [IDX_W-1:0]             rel_idx,
    input  logic                         flush,
    output logic                         full,
    output logic                         empty,
    output logic [IDX_W:0]               count,
    output logic                         err_wr
);
    RBEntryStateType       state [DEPTH];
    logic [DATA_WIDTH-1:0] data  [DEPTH];
    logic [DEPTH-1:0]      free;
    logic                  rel_eff;
    logic                  rel_hits_wr;
    logic                  wr_ok;
    logic                  err_next;
    logic [IDX_W:0]        count_next;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) free[i] = (state[i] == RB_FREE);
    end

    vs_rb_alloc_picker #(.DEPTH(DEPTH)) u_picker (
        .free (free),
        .idx  (alloc_idx)
    );

    assign full      = (count == (IDX_W + 1)'(DEPTH));
    assign empty     = (count == '0);
    assign alloc_gnt = alloc_req & ~full & ~flush & ~rst;

    // Releasing a FREE entry must not cancel a grant landing on that same entry.
    assign rel_eff     = rel_en && (state[rel_idx] != RB_FREE);
    assign rel_hits_wr = rel_en && (rel_idx == wr_idx);
    assign wr_ok       = wr_en && !flush && !rel_hits_wr && (state[wr_idx] == RB_ALLOC);
    assign err_next    = wr_en && !flush && !rel_hits_wr && (state[wr_idx] != RB_ALLOC);

    always_comb begin
        count_next = count + (IDX_W + 1)'(alloc_gnt) - (IDX_W + 1)'(rel_eff);
        if (flush) count_next = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                state[i] <= RB_FREE;
                data[i]  <= '0;
            end
            count  <= '0;
            err_wr <= 1'b0;
        end else begin
            count  <= count_next;
            err_wr <= err_next;
            if (flush) begin
                for (int i = 0; i < DEPTH; i++) state[i] <= RB_FREE;
            end else begin
                if (wr_ok) begin
                    state[wr_idx] <= RB_VALID;
                    data[wr_idx]  <= wr_data;
                end
                if (alloc_gnt) state[alloc_idx] <= RB_ALLOC;
                if (rel_eff)   state[rel_idx]   <= RB_FREE;
            end
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [IDX_W-1:0] sel;
        logic             hit;
        logic             byp;

        assign sel = rd_idx[p*IDX_W +: IDX_W];
        assign hit = (state[sel] == RB_VALID);
`ifdef VS_RB_BYPASS_EN
        assign byp = wr_ok && (wr_idx == sel);
`else
        assign byp = 1'b0;
`endif
        assign rd_valid[p] = hit | byp;
        assign rd_data[p*DATA_WIDTH +: DATA_WIDTH] = byp ? wr_data : (hit ? data[sel] : '0);
    end
endmodule

// File: tb/tb_vs_result_buffer.sv
// Directed and randomized bench for vs_result_buffer against an entry-table reference model.
module tb_vs_result_buffer;
    localparam int DW = 32;
    localparam int DEPTH = 8;
    localparam int NRD = 2;
    localparam int IW = 3;
    localparam int S_FREE = 0, S_ALLOC = 1, S_VALID = 2;

    logic            clk = 0;
    logic            rst;
    logic            alloc_req;
    logic            alloc_gnt;
    logic [IW-1:0]   alloc_idx;
    logic            wr_en;
    logic [IW-1:0]   wr_idx;
    logic [DW-1:0]   wr_data;
    logic [NRD*IW-1:0] rd_idx;
    logic [NRD*DW-1:0] rd_data;
    logic [NRD-1:0]  rd_valid;
    logic            rel_en;
    logic [IW-1:0]   rel_idx;
    logic            flush;
    logic            full;
    logic            empty;
    logic [IW:0]     count;
    logic            err_wr;

    int n_chk = 0;
    int n_fail = 0;

    int          mstate [DEPTH];
    logic [31:0] mdata  [DEPTH];
    bit          merr;

    vs_result_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_RD(NRD)) dut (
        .clk(clk), .rst(rst), .alloc_req(alloc_req), .alloc_gnt(alloc_gnt), .alloc_idx(alloc_idx),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data), .rd_idx(rd_idx), .rd_data(rd_data),
        .rd_valid(rd_valid), .rel_en(rel_en), .rel_idx(rel_idx), .flush(flush), .full(full),
        .empty(empty), .count(count), .err_wr(err_wr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            mstate[i] = S_FREE;
            mdata[i] = '0;
        end
        merr = 0;
    endtask

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < DEPTH; i++) if (mstate[i] != S_FREE) c++;
        return c;
    endfunction

    function automatic int m_lowest_free();
        for (int i = 0; i < DEPTH; i++) if (mstate[i] == S_FREE) return i;
        return 0;
    endfunction

    task automatic check_all(input string tag);
        int c;
        bit g;
        c = m_count();
        g = alloc_req && (c != DEPTH) && !flush && !rst;
        chk({tag, ".gnt"}, alloc_gnt, g);
        chk({tag, ".idx"}, alloc_idx, m_lowest_free());
        chk({tag, ".count"}, count, c);
        chk({tag, ".full"}, full, c == DEPTH);
        chk({tag, ".empty"}, empty, c == 0);
        chk({tag, ".err"}, err_wr, merr);
        for (int p = 0; p < NRD; p++) begin
            int s;
            bit ev;
            logic [31:0] ed;
            s = int'(rd_idx[p*IW +: IW]);
            ev = (mstate[s] == S_VALID);
            ed = ev ? mdata[s] : 32'h0;
`ifdef VS_RB_BYPASS_EN
            if (mstate[s] == S_ALLOC && wr_en && wr_idx == s && !flush && !(rel_en && rel_idx == s)) begin
                ev = 1;
                ed = wr_data;
            end
`endif
            chk({tag, ".rdv"}, rd_valid[p], ev);
            chk({tag, ".rdd"}, rd_data[p*DW +: DW], ed);
        end
    endtask

    task automatic model_edge();
        bit g;
        int a;
        bit e;
        g = alloc_req && (m_count() != DEPTH) && !flush;
        a = m_lowest_free();
        e = 0;
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) mstate[i] = S_FREE;
        end else begin
            if (wr_en && !(rel_en && rel_idx == wr_idx)) begin
                if (mstate[wr_idx] == S_ALLOC) begin
                    mstate[wr_idx] = S_VALID;
                    mdata[wr_idx] = wr_data;
                end else e = 1;
            end
            if (rel_en) mstate[rel_idx] = S_FREE;
            if (g) mstate[a] = S_ALLOC;
        end
        merr = e;
    endtask

    task automatic idle();
        alloc_req = 0; wr_en = 0; wr_idx = 0; wr_data = 0; rel_en = 0; rel_idx = 0; flush = 0;
    endtask

    task automatic settle(input string tag);
        #3;
        check_all(tag);
    endtask

    task automatic advance();
        model_edge();
        @(posedge clk);
        #1;
        idle();
    endtask

    initial begin
        idle();
        rd_idx = 0;
        rst = 1;
        alloc_req = 1;
        model_reset();
        settle("reset");
        chk("reset.gnt0", alloc_gnt, 0);
        chk("reset.empty1", empty, 1);
        @(posedge clk); #1;
        rst = 0;
        idle();

        // fill all 8 entries
        for (int i = 0; i < DEPTH; i++) begin
            alloc_req = 1;
            settle("fill");
            chk("fill.idx_seq", alloc_idx, i);
            advance();
        end
        alloc_req = 1;
        settle("full");
        chk("full.flag", full, 1);
        chk("full.count8", count, 8);
        chk("full.nogrant", alloc_gnt, 0);

        // release and alloc in the same cycle
        rel_en = 1; rel_idx = 2; alloc_req = 1;
        settle("relalloc");
        chk("relalloc.gnt0", alloc_gnt, 0);
        advance();
        alloc_req = 1;
        settle("realloc");
        chk("realloc.idx2", alloc_idx, 2);
        chk("realloc.gnt1", alloc_gnt, 1);
        advance();

        flush = 1;
        settle("flush1");
        advance();

        // allocate 0..3, write 3 then read it back
        for (int i = 0; i < 4; i++) begin
            alloc_req = 1;
            settle("alloc4");
            advance();
        end
        wr_en = 1; wr_idx = 3; wr_data = 32'hDEADBEEF;
        settle("wr3");
        advance();
        rd_idx = {3'd0, 3'd3};
        settle("rd3");
        chk("rd3.valid", rd_valid[0], 1);
        chk("rd3.data", rd_data[31:0], 32'hDEADBEEF);

        // write to a FREE entry
        wr_en = 1; wr_idx = 5; wr_data = 32'h55;
        settle("wrfree");
        advance();
        settle("wrfree.next");
        chk("wrfree.err1", err_wr, 1);
        chk("wrfree.count", count, 4);
        advance();
        settle("wrfree.after");
        chk("wrfree.err0", err_wr, 0);

        // four valid entries, then flush with alloc and write
        for (int i = 0; i < 3; i++) begin
            wr_en = 1; wr_idx = IW'(i); wr_data = 32'hA0 + i;
            settle("wrv");
            advance();
        end
        flush = 1; alloc_req = 1; wr_en = 1; wr_idx = 4; wr_data = 32'h99;
        settle("flush2");
        chk("flush2.nogrant", alloc_gnt, 0);
        advance();
        rd_idx = {3'd1, 3'd3};
        settle("flush2.after");
        chk("flush2.count0", count, 0);
        chk("flush2.empty", empty, 1);
        chk("flush2.rdv", rd_valid, 2'b00);

        // same-cycle write and read of idx 1
        alloc_req = 1; settle("byp.a0"); advance();
        alloc_req = 1; settle("byp.a1"); advance();
        wr_en = 1; wr_idx = 1; wr_data = 32'h12; rd_idx = {3'd1, 3'd0};
        settle("byp.same");
`ifdef VS_RB_BYPASS_EN
        chk("byp.same.v", rd_valid[1], 1);
        chk("byp.same.d", rd_data[63:32], 32'h12);
`else
        chk("byp.same.v", rd_valid[1], 0);
`endif
        advance();
        settle("byp.next");
        chk("byp.next.v", rd_valid[1], 1);
        chk("byp.next.d", rd_data[63:32], 32'h12);

        // reset mid-operation discards a pending write
        alloc_req = 1; settle("mid.a"); advance();
        wr_en = 1; wr_idx = 2; wr_data = 32'hCAFE;
        #1;
        rst = 1;
        model_reset();
        settle("mid.rst");
        @(posedge clk); #1;
        rst = 0;
        idle();
        rd_idx = {3'd2, 3'd2};
        alloc_req = 1;
        settle("mid.after");
        chk("mid.first_idx0", alloc_idx, 0);
        chk("mid.gnt", alloc_gnt, 1);
        chk("mid.rd2", rd_valid[0], 0);
        advance();

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            alloc_req = ($urandom_range(0, 99) < 55);
            wr_en = ($urandom_range(0, 99) < 50);
            wr_idx = IW'($urandom_range(0, DEPTH - 1));
            wr_data = $urandom;
            rel_en = ($urandom_range(0, 99) < 30);
            rel_idx = IW'($urandom_range(0, DEPTH - 1));
            flush = ($urandom_range(0, 99) < 3);
            rd_idx = NRD*IW'($urandom);
            if ($urandom_range(0, 3) == 0) rd_idx[IW-1:0] = wr_idx;
            settle("rand");
            advance();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
